adder_result_checker: RTL and testbench

Self-checking response monitor for the 16-bit adder family (carry-select and other adder variants). It sits at the output end of a device under test (DUT) adder. It takes each applied operand set {a, b, cin} together with the DUT's {sum, cout}, computes the golden result, and compares the two. It keeps pass/fail counts, a sticky error flag, and the first failing vector, so an adder can be signed off on silicon/FPGA without a $monitor log.

---
 rtl/adder_result_checker.sv | 139 +++++++++++++
 tb/tb_adder_result_checker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_checker.sv
// Golden-model response checker for a WIDTH-bit adder: registers each vector, recomputes a+b+cin
// and compares it against the DUT's {cout,sum}. Results appear two cycles later. There is no backpressure.
`timescale 1ns/1ps
module adder_result_checker #(
  parameter int WIDTH        = 16,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  input  logic             clear,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err_sticky,
  output logic             halted,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output logic [WIDTH-1:0] ff_sum,
  output logic             ff_cout
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             s1_vld;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_sum;
  logic             s1_cout;
  logic [WIDTH:0]   s1_golden;

  logic mismatch;
  logic halt_now;
  logic accept;

  assign mismatch = s1_vld && ({s1_cout, s1_sum} != s1_golden);
  assign halt_now = STOP_ON_FAIL && mismatch && (state == RUN);
  // The vector arriving on the halting edge is discarded along with all later ones.
  assign accept   = in_valid && (state != HALT) && !halt_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      halted <= 1'b0;
    end else if (clear) begin
      state  <= IDLE;
      halted <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) state <= RUN;
        RUN: begin
          if (halt_now) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: state <= HALT;
        default: begin
          state  <= IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_sum    <= '0;
      s1_cout   <= 1'b0;
      s1_golden <= '0;
    end else if (clear) begin
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_a      <= in_a;
        s1_b      <= in_b;
        s1_sum    <= dut_sum;
        s1_cout   <= dut_cout;
        s1_golden <= {1'b0, in_a} + {1'b0, in_b} + (WIDTH+1)'(in_cin);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_valid  <= 1'b0;
      chk_pass   <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      err_sticky <= 1'b0;
      ff_a       <= '0;
      ff_b       <= '0;
      ff_sum     <= '0;
      ff_cout    <= 1'b0;
    end else if (clear) begin
      chk_valid  <= 1'b0;
      chk_pass   <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      err_sticky <= 1'b0;
      ff_a       <= '0;
      ff_b       <= '0;
      ff_sum     <= '0;
      ff_cout    <= 1'b0;
    end else begin
      chk_valid <= s1_vld;
      chk_pass  <= s1_vld && !mismatch;
      if (s1_vld && !mismatch) begin
        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
      end
      if (mismatch) begin
        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
        err_sticky <= 1'b1;
        // Only the first failure since clear/reset is kept for debug.
        if (!err_sticky) begin
          ff_a    <= s1_a;
          ff_b    <= s1_b;
          ff_sum  <= s1_sum;
          ff_cout <= s1_cout;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_result_checker.sv
// Scoreboard bench: three checker instances (default, stop-on-fail, 4-bit counters) on shared stimulus.
`timescale 1ns/1ps
module tb_adder_result_checker;

  typedef struct packed {
    logic        vld;
    logic        pass;
    logic [15:0] pc;
    logic [15:0] fc;
    logic        err;
    logic        halt;
    logic [15:0] ffa;
    logic [15:0] ffb;
    logic [15:0] ffs;
    logic        ffc;
  } exp_t;

  typedef struct packed {
    logic [31:0]     cyc;
    exp_t [2:0]      e;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic [15:0] dut_sum = '0;
  logic        dut_cout = 1'b0;
  logic        clear = 1'b0;

  logic        cv [3];
  logic        cp [3];
  logic        hl [3];
  logic        er [3];
  logic        ffc_o [3];
  logic [15:0] ffa_o [3];
  logic [15:0] ffb_o [3];
  logic [15:0] ffs_o [3];
  logic [15:0] pc0, fc0, pc1, fc1;
  logic [3:0]  pc2, fc2;

  logic [31:0] cyc = '0;
  int          checks = 0;
  int          failures = 0;
  entry_t      q[$];
  exp_t        m [3];
  exp_t        cur [3];
  bit          flush_pend = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_result_checker #(.WIDTH(16), .CNT_W(16), .STOP_ON_FAIL(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .dut_sum(dut_sum), .dut_cout(dut_cout), .clear(clear), .chk_valid(cv[0]), .chk_pass(cp[0]),
    .pass_cnt(pc0), .fail_cnt(fc0), .err_sticky(er[0]), .halted(hl[0]),
    .ff_a(ffa_o[0]), .ff_b(ffb_o[0]), .ff_sum(ffs_o[0]), .ff_cout(ffc_o[0]));

  adder_result_checker #(.WIDTH(16), .CNT_W(16), .STOP_ON_FAIL(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .dut_sum(dut_sum), .dut_cout(dut_cout), .clear(clear), .chk_valid(cv[1]), .chk_pass(cp[1]),
    .pass_cnt(pc1), .fail_cnt(fc1), .err_sticky(er[1]), .halted(hl[1]),
    .ff_a(ffa_o[1]), .ff_b(ffb_o[1]), .ff_sum(ffs_o[1]), .ff_cout(ffc_o[1]));

  adder_result_checker #(.WIDTH(16), .CNT_W(4), .STOP_ON_FAIL(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .dut_sum(dut_sum), .dut_cout(dut_cout), .clear(clear), .chk_valid(cv[2]), .chk_pass(cp[2]),
    .pass_cnt(pc2), .fail_cnt(fc2), .err_sticky(er[2]), .halted(hl[2]),
    .ff_a(ffa_o[2]), .ff_b(ffb_o[2]), .ff_sum(ffs_o[2]), .ff_cout(ffc_o[2]));

  function automatic exp_t act(input int i);
    exp_t r;
    r.vld  = cv[i];
    r.pass = cp[i] & cv[i];
    r.pc   = (i == 0) ? pc0 : (i == 1) ? pc1 : {12'b0, pc2};
    r.fc   = (i == 0) ? fc0 : (i == 1) ? fc1 : {12'b0, fc2};
    r.err  = er[i];
    r.halt = hl[i];
    r.ffa  = ffa_o[i];
    r.ffb  = ffb_o[i];
    r.ffs  = ffs_o[i];
    r.ffc  = ffc_o[i];
    return r;
  endfunction

  task automatic cmp(input string nm, input int i, input exp_t got, input exp_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s u%0d cyc=%0d got=%h exp=%h", nm, i, cyc, got, want);
    end
  endtask

  task automatic flush();
    q.delete();
    for (int i = 0; i < 3; i++) begin
      m[i]   = '0;
      cur[i] = '0;
    end
  endtask

  // Reference model: evaluated at issue time from the adder arithmetic; the result is due two cycles later.
  task automatic push_vec(input logic [15:0] a, b, input logic cin, input logic [15:0] s, input logic co);
    int     g;
    logic   good;
    entry_t en;
    int     mx;
    g    = int'(a) + int'(b) + int'(cin);
    good = (int'({co, s}) == g);
    en.cyc = cyc + 2;
    for (int i = 0; i < 3; i++) begin
      mx = (i == 2) ? 15 : 65535;
      if (m[i].halt) begin
        m[i].vld  = 1'b0;
        m[i].pass = 1'b0;
      end else begin
        m[i].vld  = 1'b1;
        m[i].pass = good;
        if (good) begin
          if (int'(m[i].pc) < mx) m[i].pc = m[i].pc + 16'd1;
        end else begin
          if (int'(m[i].fc) < mx) m[i].fc = m[i].fc + 16'd1;
          if (!m[i].err) begin
            m[i].ffa = a;
            m[i].ffb = b;
            m[i].ffs = s;
            m[i].ffc = co;
          end
          m[i].err = 1'b1;
          if (i == 1) m[i].halt = 1'b1;
        end
      end
      en.e[i] = m[i];
    end
    q.push_back(en);
  endtask

  always @(negedge clk) begin
    bit hit;
    if (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL stale_entry cyc=%0d due=%0d", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    hit = (q.size() > 0) && (q[0].cyc == cyc);
    for (int i = 0; i < 3; i++) begin
      if (hit) cur[i] = q[0].e[i];
      else begin
        cur[i].vld  = 1'b0;
        cur[i].pass = 1'b0;
      end
      cmp("outputs", i, act(i), cur[i]);
    end
    if (hit) void'(q.pop_front());
  end

  task automatic step_begin();
    @(posedge clk);
    #1;
    if (flush_pend) begin
      flush();
      flush_pend = 0;
    end
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic issue(input logic [15:0] a, b, input logic cin, input logic [15:0] s, input logic co);
    step_begin();
    in_valid = 1'b1;
    in_a = a; in_b = b; in_cin = cin; dut_sum = s; dut_cout = co;
    push_vec(a, b, cin, s, co);
  endtask

  task automatic issue_rand(input int err_pct);
    logic [15:0] a, b;
    logic        cin;
    logic [16:0] r;
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom);
    r   = 17'(int'(a) + int'(b) + int'(cin));
    if ($urandom_range(99, 0) < err_pct) r = r ^ (17'd1 << $urandom_range(16, 0));
    issue(a, b, cin, r[15:0], r[16]);
  endtask

  task automatic do_clear(input logic with_vld);
    step_begin();
    clear    = 1'b1;
    in_valid = with_vld;
    in_a = 16'($urandom); in_b = 16'($urandom); dut_sum = 16'($urandom);
    flush_pend = 1;
  endtask

  task automatic do_reset();
    step_begin();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) cmp("async_reset_zero", i, act(i), exp_t'(0));
    flush();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    flush();
    #2;
    for (int i = 0; i < 3; i++) cmp("reset_zero", i, act(i), exp_t'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue(16'hA0A0, 16'hA0A0, 1'b0, 16'h4140, 1'b1);
    issue(16'h58F4, 16'hF4F4, 1'b0, 16'h4DE8, 1'b1);
    issue(16'h0F3D, 16'h0F0F, 1'b0, 16'h1E4C, 1'b0);
    issue(16'hC8CA, 16'hC8CA, 1'b0, 16'h9194, 1'b1);
    issue(16'h0F3D, 16'h0F0F, 1'b0, 16'h1E4D, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0);
    issue(16'hA0A0, 16'hA0A0, 1'b0, 16'h4140, 1'b0);
    issue(16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0);
    for (int i = 0; i < 3; i++) step_begin();
    do_clear(1'b0);
    for (int i = 0; i < 20; i++) issue_rand(0);
    do_clear(1'b1);
    issue_rand(0);
    issue_rand(100);
    issue_rand(0);
    do_clear(1'b1);
    for (int i = 0; i < 2; i++) step_begin();

    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(999, 0);
      if (r < 15)      do_clear(1'($urandom));
      else if (r < 20) do_reset();
      else if (r < 120) step_begin();
      else             issue_rand(15);
    end

    for (int i = 0; i < 5; i++) step_begin();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
